rx_store_copy_engine: RTL and testbench



---
 rtl/rx_store_copy_pkg.sv | 23 ++
 rtl/rx_store_copy_engine_mask_gen.sv | 23 ++
 rtl/rx_store_copy_engine.sv | 171 +++++++++++++++++
 tb/tb_rx_store_copy_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_store_copy_pkg.sv
// Shared types and default widths for the RX payload store copy engine.
package rx_store_copy_pkg;

  localparam int unsigned DefDataW    = 512;
  localparam int unsigned DefTmpAddrW = 8;
  localparam int unsigned DefDstAddrW = 32;
  localparam int unsigned DefLenW     = 16;
  localparam int unsigned DefBytes    = DefDataW / 8;
  localparam int unsigned BYTES_W     = $clog2(DefBytes);

  typedef enum logic [1:0] {
    StIdle,
    StCopy,
    StDone
  } state_e;

  typedef struct packed {
    logic [DefTmpAddrW-1:0] tmp_addr;
    logic [DefDstAddrW-1:0] dst_addr;
    logic [DefLenW-1:0]     len;
  } store_cmd_t;

endpackage

// File: rtl/rx_store_copy_engine_mask_gen.sv
// Byte-enable generator: full mask except a partial final line of rem bytes.
module rx_store_copy_mask_gen
  import rx_store_copy_pkg::*;
#(
  parameter int unsigned BYTES = DefBytes,
  parameter int unsigned BW    = $clog2(BYTES)
) (
  input  logic [BW-1:0]    rem,
  input  logic             last,
  output logic [BYTES-1:0] wr_mask
);

  logic partial;

  always_comb begin
    partial = last && (rem != '0);
    wr_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      wr_mask[i] = !partial || (i < int'(rem));
    end
  end

endmodule

// File: rtl/rx_store_copy_engine.sv
// RX payload store stage: reads temp buffer lines and forwards them as masked payload writes.
// Optional RX_STORE_COPY_STATS_EN adds stat_lines / stat_stall counters.
module rx_store_copy_engine
  import rx_store_copy_pkg::*;
#(
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned TMP_ADDR_W = DefTmpAddrW,
  parameter int unsigned DST_ADDR_W = DefDstAddrW,
  parameter int unsigned LEN_W      = DefLenW,
  parameter int unsigned MAX_OUT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_val,
  input  logic [TMP_ADDR_W-1:0] cmd_tmp_addr,
  input  logic [DST_ADDR_W-1:0] cmd_dst_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  cmd_rdy,
  output logic                  store_buf_tmp_buf_store_rx_rd_req_val,
  output logic [TMP_ADDR_W-1:0] store_buf_tmp_buf_store_rx_rd_req_addr,
  input  logic                  tmp_buf_store_store_buf_rx_rd_req_rdy,
  input  logic                  tmp_buf_store_store_buf_rx_rd_resp_val,
  input  logic [DATA_W-1:0]     tmp_buf_store_store_buf_rx_rd_resp_data,
  output logic                  store_buf_tmp_buf_store_rx_rd_resp_rdy,
  output logic                  wr_val,
  output logic [DST_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W/8-1:0]   wr_mask,
  input  logic                  wr_rdy,
  output logic                  done_val,
  input  logic                  done_rdy
`ifdef RX_STORE_COPY_STATS_EN
  ,
  output logic [31:0]           stat_lines,
  output logic [31:0]           stat_stall
`endif
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned BW    = $clog2(BYTES);
  localparam int unsigned LineW = LEN_W - BW + 1;

  state_e                state_q, state_d;
  logic [TMP_ADDR_W-1:0] tmp_q, tmp_d;
  logic [DST_ADDR_W-1:0] dst_q, dst_d;
  logic [LineW-1:0]      lines_q, lines_d;
  logic [BW-1:0]         rem_q, rem_d;
  logic [LineW-1:0]      req_cnt_q, req_cnt_d;
  logic [LineW-1:0]      resp_cnt_q, resp_cnt_d;

  logic [LEN_W:0]        len_round;
  logic [LineW-1:0]      lines_calc;
  logic [LineW-1:0]      outstanding;
  logic                  last_line;
  logic [BYTES-1:0]      mask_raw;

  // ceil(len / BYTES) without a divider
  assign len_round   = {1'b0, cmd_len} + (LEN_W+1)'(BYTES - 1);
  assign lines_calc  = len_round[LEN_W:BW];
  assign outstanding = req_cnt_q - resp_cnt_q;
  assign last_line   = (resp_cnt_q == lines_q - LineW'(1));

  assign store_buf_tmp_buf_store_rx_rd_req_addr = tmp_q + TMP_ADDR_W'(req_cnt_q);
  assign wr_addr = dst_q + (DST_ADDR_W'(resp_cnt_q) << BW);
  assign wr_data = tmp_buf_store_store_buf_rx_rd_resp_data;
  assign wr_mask = (state_q == StCopy) ? mask_raw : '0;

  rx_store_copy_mask_gen #(
    .BYTES (BYTES),
    .BW    (BW)
  ) u_mask_gen (
    .rem     (rem_q),
    .last    (last_line),
    .wr_mask (mask_raw)
  );

  always_comb begin
    state_d    = state_q;
    tmp_d      = tmp_q;
    dst_d      = dst_q;
    lines_d    = lines_q;
    rem_d      = rem_q;
    req_cnt_d  = req_cnt_q;
    resp_cnt_d = resp_cnt_q;
    cmd_rdy    = 1'b0;
    done_val   = 1'b0;
    wr_val     = 1'b0;
    store_buf_tmp_buf_store_rx_rd_req_val  = 1'b0;
    store_buf_tmp_buf_store_rx_rd_resp_rdy = 1'b0;
    unique case (state_q)
      StIdle: begin
        cmd_rdy = !rst;
        if (cmd_val && cmd_rdy) begin
          tmp_d      = cmd_tmp_addr;
          dst_d      = cmd_dst_addr;
          lines_d    = lines_calc;
          rem_d      = cmd_len[BW-1:0];
          req_cnt_d  = '0;
          resp_cnt_d = '0;
          state_d    = (lines_calc != '0) ? StCopy : StDone;
        end
      end
      StCopy: begin
        store_buf_tmp_buf_store_rx_rd_req_val =
            (req_cnt_q < lines_q) && (outstanding < LineW'(MAX_OUT));
        store_buf_tmp_buf_store_rx_rd_resp_rdy = wr_rdy;
        wr_val = tmp_buf_store_store_buf_rx_rd_resp_val;
        if (store_buf_tmp_buf_store_rx_rd_req_val && tmp_buf_store_store_buf_rx_rd_req_rdy) begin
          req_cnt_d = req_cnt_q + LineW'(1);
        end
        if (wr_val && wr_rdy) begin
          resp_cnt_d = resp_cnt_q + LineW'(1);
          if (last_line) state_d = StDone;
        end
      end
      StDone: begin
        done_val = 1'b1;
        if (done_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      tmp_q      <= '0;
      dst_q      <= '0;
      lines_q    <= '0;
      rem_q      <= '0;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tmp_q      <= tmp_d;
      dst_q      <= dst_d;
      lines_q    <= lines_d;
      rem_q      <= rem_d;
      req_cnt_q  <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end

`ifdef RX_STORE_COPY_STATS_EN
  logic [31:0] stat_lines_q, stat_lines_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_lines_d = stat_lines_q;
    stat_stall_d = stat_stall_q;
    if (wr_val && wr_rdy) stat_lines_d = stat_lines_q + 32'd1;
    if (store_buf_tmp_buf_store_rx_rd_req_val && !tmp_buf_store_store_buf_rx_rd_req_rdy) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lines_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_lines_q <= stat_lines_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_lines = stat_lines_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_rx_store_copy_engine.sv
// Self-checking bench for rx_store_copy_engine: directed table, reset abort, random commands.
module tb_rx_store_copy_engine;

  localparam int DATA_W     = 512;
  localparam int TMP_ADDR_W = 8;
  localparam int DST_ADDR_W = 32;
  localparam int LEN_W      = 16;
  localparam int MAX_OUT    = 2;
  localparam int BYTES      = DATA_W / 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  cmd_val;
  logic [TMP_ADDR_W-1:0] cmd_tmp_addr;
  logic [DST_ADDR_W-1:0] cmd_dst_addr;
  logic [LEN_W-1:0]      cmd_len;
  logic                  cmd_rdy;
  logic                  rd_req_val;
  logic [TMP_ADDR_W-1:0] rd_req_addr;
  logic                  rd_req_rdy;
  logic                  rd_resp_val;
  logic [DATA_W-1:0]     rd_resp_data;
  logic                  rd_resp_rdy;
  logic                  wr_val;
  logic [DST_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [BYTES-1:0]      wr_mask;
  logic                  wr_rdy;
  logic                  done_val;
  logic                  done_rdy;
`ifdef RX_STORE_COPY_STATS_EN
  logic [31:0]           stat_lines;
  logic [31:0]           stat_stall;
`endif

  rx_store_copy_engine #(
    .DATA_W     (DATA_W),
    .TMP_ADDR_W (TMP_ADDR_W),
    .DST_ADDR_W (DST_ADDR_W),
    .LEN_W      (LEN_W),
    .MAX_OUT    (MAX_OUT)
  ) dut (
    .clk                                     (clk),
    .rst                                     (rst),
    .cmd_val                                 (cmd_val),
    .cmd_tmp_addr                            (cmd_tmp_addr),
    .cmd_dst_addr                            (cmd_dst_addr),
    .cmd_len                                 (cmd_len),
    .cmd_rdy                                 (cmd_rdy),
    .store_buf_tmp_buf_store_rx_rd_req_val   (rd_req_val),
    .store_buf_tmp_buf_store_rx_rd_req_addr  (rd_req_addr),
    .tmp_buf_store_store_buf_rx_rd_req_rdy   (rd_req_rdy),
    .tmp_buf_store_store_buf_rx_rd_resp_val  (rd_resp_val),
    .tmp_buf_store_store_buf_rx_rd_resp_data (rd_resp_data),
    .store_buf_tmp_buf_store_rx_rd_resp_rdy  (rd_resp_rdy),
    .wr_val                                  (wr_val),
    .wr_addr                                 (wr_addr),
    .wr_data                                 (wr_data),
    .wr_mask                                 (wr_mask),
    .wr_rdy                                  (wr_rdy),
    .done_val                                (done_val),
    .done_rdy                                (done_rdy)
`ifdef RX_STORE_COPY_STATS_EN
    ,
    .stat_lines                              (stat_lines),
    .stat_stall                              (stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] salt = 32'h1234_5678;

  // Temp buffer model: requests become readable one cycle after acceptance.
  int tb_addr_q[$];
  int tb_time_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          len;
    int          tmp;
    int          dst;
    int          stall;
    int          exp_lines;
    logic [63:0] exp_last_mask;
  } vec_t;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] data_of(input int a, input logic [31:0] s);
    logic [DATA_W-1:0] d;
    for (int j = 0; j < DATA_W / 32; j++) begin
      d[32*j +: 32] = (32'(a) * 32'h9E37_79B1) ^ (32'(j) * 32'h0101_0101) ^ s;
    end
    return d;
  endfunction

  function automatic logic [63:0] exp_mask(input int i, input int lines, input int rem);
    if (i == lines - 1 && rem != 0) return (64'd1 << rem) - 64'd1;
    return {64{1'b1}};
  endfunction

  task automatic set_idle_inputs();
    cmd_val      = 1'b0;
    rd_req_rdy   = 1'b0;
    rd_resp_val  = 1'b0;
    rd_resp_data = '0;
    wr_rdy       = 1'b0;
    done_rdy     = 1'b0;
  endtask

  // Runs one command from the idle state. abort_at > 0 returns after that many writes.
  task automatic run_cmd(input int len, input int tmp, input int dst, input int stall,
                         input bit rnd, input int abort_at,
                         output int nwr, output logic [63:0] last_mask);
    int lines = (len + BYTES - 1) / BYTES;
    int rem   = len % BYTES;
    int nreq  = 0;
    int k     = 0;
    int last_wr_k = -1;
    bit done  = 0;
    nwr       = 0;
    last_mask = '0;
    salt      = $urandom;
    @(negedge clk);
    cmd_val      = 1'b1;
    cmd_len      = LEN_W'(len);
    cmd_tmp_addr = TMP_ADDR_W'(tmp);
    cmd_dst_addr = DST_ADDR_W'(dst);
    #1;
    chk("cmd_rdy_idle", DATA_W'(cmd_rdy), DATA_W'(1));
    @(posedge clk);
    @(negedge clk);
    cmd_val = 1'b0;
    while (!done && k < 3000) begin
      if (abort_at > 0 && nwr >= abort_at) return;
      rd_req_rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_rdy     = (k < stall) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      done_rdy   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (tb_addr_q.size() > 0 && tb_time_q[0] <= cyc) begin
        rd_resp_val  = 1'b1;
        rd_resp_data = data_of(tb_addr_q[0], salt);
      end else begin
        rd_resp_val  = 1'b0;
        rd_resp_data = {16{32'($urandom)}};
      end
      #1;
      if (k == 0) chk("cmd_rdy_busy", DATA_W'(cmd_rdy), DATA_W'(0));
      if (rd_req_val) begin
        chk("req_within_lines", DATA_W'(nreq < lines), DATA_W'(1));
        chk("outstanding_cap", DATA_W'((nreq - nwr) < MAX_OUT), DATA_W'(1));
        if (rd_req_rdy) begin
          chk("rd_addr", DATA_W'(rd_req_addr), DATA_W'((tmp + nreq) % (1 << TMP_ADDR_W)));
          tb_addr_q.push_back((tmp + nreq) % (1 << TMP_ADDR_W));
          tb_time_q.push_back(cyc + 1);
          nreq++;
        end
      end
      if (stall > 3 && k == 3) begin
        chk("stall_req_val_low", DATA_W'(rd_req_val), DATA_W'(0));
        chk("stall_outstanding", DATA_W'(nreq - nwr), DATA_W'(MAX_OUT));
      end
      if (rd_resp_val) begin
        chk("wr_val_pass", DATA_W'(wr_val), DATA_W'(1));
        chk("resp_rdy_pass", DATA_W'(rd_resp_rdy), DATA_W'(wr_rdy));
        if (wr_rdy) begin
          chk("wr_addr", DATA_W'(wr_addr), DATA_W'(dst + nwr * BYTES));
          chk("wr_mask", DATA_W'(wr_mask), DATA_W'(exp_mask(nwr, lines, rem)));
          chk("wr_data", wr_data, data_of((tmp + nwr) % (1 << TMP_ADDR_W), salt));
          last_mask = wr_mask;
          void'(tb_addr_q.pop_front());
          void'(tb_time_q.pop_front());
          nwr++;
          last_wr_k = k;
        end
      end else begin
        chk("wr_val_idle", DATA_W'(wr_val), DATA_W'(0));
      end
      chk("done_val", DATA_W'(done_val), DATA_W'(nwr == lines && k > last_wr_k));
      if (done_val && done_rdy) done = 1;
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    set_idle_inputs();
    chk("cmd_timeout", DATA_W'(done), DATA_W'(1));
    chk("req_total", DATA_W'(nreq), DATA_W'(lines));
  endtask

  vec_t vecs[$];

  initial begin
    int          nwr;
    logic [63:0] lm;
    vecs.push_back('{128, 5, 'h1000, 0, 2, {64{1'b1}}});
    vecs.push_back('{100, 9, 'h2000, 0, 2, 64'h0000_000F_FFFF_FFFF});
    vecs.push_back('{0, 3, 'h40, 0, 0, 64'h0});
    vecs.push_back('{512, 20, 'h8000, 6, 8, {64{1'b1}}});
    vecs.push_back('{128, 255, 'h3000, 0, 2, {64{1'b1}}});
    vecs.push_back('{1, 7, 'h0, 0, 1, 64'h1});
    vecs.push_back('{65, 1, 'h100, 0, 2, 64'h1});

    set_idle_inputs();
    cmd_len = '0; cmd_tmp_addr = '0; cmd_dst_addr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_cmd_rdy", DATA_W'(cmd_rdy), DATA_W'(0));
    chk("rst_rd_req_val", DATA_W'(rd_req_val), DATA_W'(0));
    chk("rst_wr_val", DATA_W'(wr_val), DATA_W'(0));
    chk("rst_done_val", DATA_W'(done_val), DATA_W'(0));
    chk("rst_wr_mask", DATA_W'(wr_mask), DATA_W'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_rdy", DATA_W'(cmd_rdy), DATA_W'(1));

    foreach (vecs[i]) begin
      run_cmd(vecs[i].len, vecs[i].tmp, vecs[i].dst, vecs[i].stall, 1'b0, 0, nwr, lm);
      chk($sformatf("vec%0d_writes", i), DATA_W'(nwr), DATA_W'(vecs[i].exp_lines));
      chk($sformatf("vec%0d_last_mask", i), DATA_W'(lm), DATA_W'(vecs[i].exp_last_mask));
    end

    // Reset while copying, after the first write.
    run_cmd(512, 40, 'h4000, 0, 1'b0, 1, nwr, lm);
    rst = 1'b1;
    tb_addr_q.delete();
    tb_time_q.delete();
    set_idle_inputs();
    #1;
    chk("abort_cmd_rdy_in_rst", DATA_W'(cmd_rdy), DATA_W'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_rd_req_val", DATA_W'(rd_req_val), DATA_W'(0));
    chk("abort_wr_val", DATA_W'(wr_val), DATA_W'(0));
    chk("abort_done_val", DATA_W'(done_val), DATA_W'(0));
    chk("abort_cmd_rdy", DATA_W'(cmd_rdy), DATA_W'(1));
    run_cmd(192, 60, 'h5000, 0, 1'b0, 0, nwr, lm);
    chk("after_abort_writes", DATA_W'(nwr), DATA_W'(3));

    for (int r = 0; r < 25; r++) begin
      int len = $urandom_range(0, 700);
      run_cmd(len, $urandom_range(0, 255), int'($urandom & 32'h00FF_FFC0), 0, 1'b1, 0, nwr, lm);
      chk("rand_writes", DATA_W'(nwr), DATA_W'((len + BYTES - 1) / BYTES));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
